tick_gen: RTL

Parametrised multi-channel clock/tick generator; successor to the fixed three-output `clocks` divider. Each channel has a runtime-programmable divisor and produces two outputs: a one-cycle `tick` strobe and a near-50% square wave `sq`. Divisor changes are glitch-free, and a global restart phase-aligns all channels. It sits at the top of the stopwatch design and feeds the counter, blink and display-scan logic from the single board clock.

---
 rtl/tick_gen_pkg.sv | 22 ++
 rtl/tick_gen_ch.sv | 110 +++++++++++
 rtl/tick_gen.sv | 46 ++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// Shared helpers for the multi-channel tick generator.
package tick_gen_pkg;

    // Helper arguments are passed at this fixed width, so DIV_W may not exceed it.
    localparam int SQ_W = 32;

    // Square-wave level for a given down-counter value and divisor.
    // The level is high while cnt >= floor(div/2), which gives ceil(div/2)
    // cycles high and floor(div/2) cycles low. A divisor of 0 means idle, so
    // the level is low.
    function automatic logic sq_level(input logic [SQ_W-1:0] cnt,
                                      input logic [SQ_W-1:0] div);
        return (div != '0) && (cnt >= (div >> 1));
    endfunction

    // Width of the channel-select field. It is at least one bit, even for a
    // single channel.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick_gen channel: active and pending divisor, down-counter,
// tick strobe and square-wave output.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int               DIV_W   = 27,
    parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic             pend_o
);

    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] reload_div;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    // Reload value for the counter. A divisor of 0 parks the counter at 0,
    // so it never underflows.
    function automatic logic [DIV_W-1:0] dec_sat(input logic [DIV_W-1:0] v);
        return (v == '0) ? '0 : v - DIV_W'(1);
    endfunction

    // Next-state logic. Priority is restart, then idle, then run.
    // A config write is folded into each branch.
    always_comb begin
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        tick_d     = 1'b0;
        sq_d       = sq_q;
        reload_div = '0;
        if (restart_i) begin
            // A write on the restart edge behaves like an already-pending
            // value, so it applies immediately.
            reload_div = wr_i ? wr_div_i : (pend_q ? div_pend_q : div_act_q);
            div_act_d  = reload_div;
            if (wr_i) div_pend_d = wr_div_i;
            pend_d     = 1'b0;
            cnt_d      = dec_sat(reload_div);
            sq_d       = (reload_div != '0);
        end else if (div_act_q == '0) begin
            // An idle channel has no period in flight, so a write takes effect at once.
            if (wr_i) begin
                div_act_d  = wr_div_i;
                div_pend_d = wr_div_i;
                pend_d     = 1'b0;
                cnt_d      = dec_sat(wr_div_i);
                sq_d       = sq_level(SQ_W'(cnt_d), SQ_W'(wr_div_i));
            end else begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end
        end else begin
            if (wr_i) begin
                div_pend_d = wr_div_i;
                pend_d     = 1'b1;
            end
            if (en_i) begin
                if (cnt_q == '0) begin
                    // Wrap: switch to the pending divisor if one is waiting.
                    // A write on this same edge stays pending.
                    reload_div = pend_q ? div_pend_q : div_act_q;
                    tick_d     = 1'b1;
                    div_act_d  = reload_div;
                    cnt_d      = dec_sat(reload_div);
                    if (!wr_i) pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
                sq_d = sq_level(SQ_W'(cnt_d), SQ_W'(div_act_d));
            end
        end
    end

    // State registers, loaded with the channel's reset divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_act_q  <= RST_DIV;
            div_pend_q <= RST_DIV;
            cnt_q      <= dec_sat(RST_DIV);
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            sq_q       <= 1'b0;
        end else begin
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            sq_q       <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick / square-wave generator. It decodes config writes
// per channel and fans out the global en and restart.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                        NUM_CH      = 4,
    parameter int                        DIV_W       = 27,
    parameter logic [NUM_CH*DIV_W-1:0]   DEFAULT_DIV = {NUM_CH{DIV_W'(2)}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          restart,
    input  logic                          cfg_we,
    input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]              cfg_div,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             sq,
    output logic [NUM_CH-1:0]             cfg_pending
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] wr;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Exact-match decode. Out-of-range channel numbers select nothing.
        assign wr[gi] = cfg_we && (cfg_ch == CH_W'(gi));

        tick_gen_ch #(
            .DIV_W   (DIV_W),
            .RST_DIV (DEFAULT_DIV[gi*DIV_W +: DIV_W])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en_i      (en),
            .restart_i (restart),
            .wr_i      (wr[gi]),
            .wr_div_i  (cfg_div),
            .tick_o    (tick[gi]),
            .sq_o      (sq[gi]),
            .pend_o    (cfg_pending[gi])
        );
    end

endmodule
